// File: rtl/adc_spi_responder.sv
// Emulates a CONVST-triggered 12-bit serial ADC. Samples come from an external
// source over a req/valid handshake; config bits arrive on DIN during the frame.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_cs,
  input  logic        adc_sclk,
  input  logic        adc_din,
  output logic        adc_dout,
  output logic        sample_req,
  output logic [2:0]  sample_chan,
  input  logic [11:0] sample_data,
  input  logic        sample_valid,
  output logic [5:0]  cfg_word,
  output logic        cfg_valid,
  output logic        busy,
  output logic        err_nodata,
  output logic        err_abort
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_READY   = 2'd2;
  localparam logic [1:0] S_SHIFT   = 2'd3;
  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [5:0] CFG_RESET = 6'b100010;

  logic [2:0]       sync_q [SYNC_STAGES];
  logic             cs_prev_q, sclk_prev_q;
  logic             cs_s, sclk_s, din_s;
  logic             cs_rise, sclk_rise, sclk_fall, start;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [11:0]      result_q, result_d;
  logic [5:0]       shreg_q, shreg_d;
  logic [5:0]       cfg_q, cfg_d;
  logic [2:0]       chan_q, chan_d;
  logic             req_q, req_d;
  logic             cfg_vld_q, cfg_vld_d;
  logic             nodata_q, nodata_d;
  logic             abort_q, abort_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {adc_cs, adc_sclk, adc_din};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign {cs_s, sclk_s, din_s} = sync_q[SYNC_STAGES-1];
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign start     = cs_rise & (state_q != S_CONVERT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    result_d  = result_q;
    shreg_d   = shreg_q;
    cfg_d     = cfg_q;
    chan_d    = chan_q;
    req_d     = req_q;
    cfg_vld_d = 1'b0;
    nodata_d  = 1'b0;
    abort_d   = 1'b0;
    if (start) begin
      // A CONVST edge outside CONVERT truncates any frame still in flight.
      state_d = S_CONVERT;
      cnt_d   = CNT_LOAD;
      req_d   = 1'b1;
      chan_d  = {cfg_q[3], cfg_q[2], cfg_q[4]};
      abort_d = (state_q != S_IDLE);
    end else begin
      case (state_q)
        S_CONVERT: begin
          // req_q stays high until a sample lands, so it doubles as "no sample yet".
          if (req_q && sample_valid) begin
            result_d = sample_data;
            req_d    = 1'b0;
          end
          if (cnt_q == '0) begin
            state_d = S_READY;
            if (req_q && !sample_valid) begin
              result_d = 12'hFFF;
              req_d    = 1'b0;
              nodata_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_READY: begin
          if (!cs_s) begin
            state_d = S_SHIFT;
            bit_d   = '0;
          end
        end
        S_SHIFT: begin
          if (sclk_rise) begin
            if (bit_q < 4'd6) shreg_d = {shreg_q[4:0], din_s};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd11) begin
              state_d   = S_IDLE;
              cfg_d     = shreg_q;
              cfg_vld_d = 1'b1;
            end
          end else if (sclk_fall) begin
            result_d = {result_q[10:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      result_q  <= '0;
      shreg_q   <= '0;
      cfg_q     <= CFG_RESET;
      chan_q    <= '0;
      req_q     <= 1'b0;
      cfg_vld_q <= 1'b0;
      nodata_q  <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      result_q  <= result_d;
      shreg_q   <= shreg_d;
      cfg_q     <= cfg_d;
      chan_q    <= chan_d;
      req_q     <= req_d;
      cfg_vld_q <= cfg_vld_d;
      nodata_q  <= nodata_d;
      abort_q   <= abort_d;
    end
  end

  // The result register shifts left on each SCLK fall, so bit 11 is the live output bit.
  assign adc_dout    = (state_q == S_SHIFT) & result_q[11];
  assign sample_req  = req_q;
  assign sample_chan = chan_q;
  assign cfg_word    = cfg_q;
  assign cfg_valid   = cfg_vld_q;
  assign busy        = (state_q != S_IDLE);
  assign err_nodata  = nodata_q;
  assign err_abort   = abort_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: directed scenarios plus randomized transactions
// checked against a rule-level model of conversion results and config updates.
module tb_adc_spi_responder;

  localparam int SYNC_STAGES = 2;
  localparam int CONV_CYCLES = 80;
  localparam int PH = SYNC_STAGES + 2;
  localparam logic [5:0] CFG_DEFAULT = 6'b100010;

  logic        clk = 1'b0;
  logic        reset, adc_cs, adc_sclk, adc_din, adc_dout;
  logic        sample_req, sample_valid, cfg_valid, busy, err_nodata, err_abort;
  logic [2:0]  sample_chan;
  logic [11:0] sample_data;
  logic [5:0]  cfg_word;

  int n_pass = 0;
  int n_chk = 0;
  int n_cfgv = 0;
  int n_nod = 0;
  int n_abt = 0;
  int n_busy_lo = 0;
  logic [5:0] m_cfg;

  adc_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .CONV_CYCLES(CONV_CYCLES)) dut (
    .clk(clk), .reset(reset), .adc_cs(adc_cs), .adc_sclk(adc_sclk), .adc_din(adc_din),
    .adc_dout(adc_dout), .sample_req(sample_req), .sample_chan(sample_chan),
    .sample_data(sample_data), .sample_valid(sample_valid), .cfg_word(cfg_word),
    .cfg_valid(cfg_valid), .busy(busy), .err_nodata(err_nodata), .err_abort(err_abort)
  );

  always #5 clk = ~clk;

  // Pulse outputs are counted per high cycle, so a stretched pulse shows as an extra count.
  always @(negedge clk) begin
    if (cfg_valid === 1'b1)  n_cfgv    <= n_cfgv + 1;
    if (err_nodata === 1'b1) n_nod     <= n_nod + 1;
    if (err_abort === 1'b1)  n_abt     <= n_abt + 1;
    if (busy !== 1'b1)       n_busy_lo <= n_busy_lo + 1;
  end

  function automatic logic [2:0] chan_of(input logic [5:0] c);
    return {c[3], c[2], c[4]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic reset_checks();
    chk("rst_cfg_word", 32'(cfg_word), 32'(CFG_DEFAULT));
    chk("rst_dout", 32'(adc_dout), 0);
    chk("rst_req", 32'(sample_req), 0);
    chk("rst_chan", 32'(sample_chan), 0);
    chk("rst_cfg_valid", 32'(cfg_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_nodata", 32'(err_nodata), 0);
    chk("rst_abort", 32'(err_abort), 0);
  endtask

  // delay < 0: no sample offered. cs_low_at: cycle (from request) CONVST drops.
  // extra: one more CONVST pulse while converting, which must be ignored.
  task automatic conversion(input int delay, input logic [11:0] data, input int cs_low_at,
                            input bit extra, output logic [11:0] exp_res, output bit exp_nod);
    bit seen;
    bit early;
    int lat;
    int lastreq;
    int lastlow;
    seen = 1'b0;
    lat = 0;
    adc_cs = 1'b1;
    for (int i = 0; i < 2 * PH && !seen; i++) begin
      tick(1);
      seen = (sample_req === 1'b1);
      lat = i + 1;
    end
    chk("req_issued", 32'(seen), 1);
    chk("req_latency", lat, SYNC_STAGES + 1);
    chk("sample_chan", 32'(sample_chan), 32'(chan_of(m_cfg)));
    exp_nod = !(delay >= 0 && delay < CONV_CYCLES);
    exp_res = exp_nod ? 12'hFFF : data;
    lastreq = exp_nod ? CONV_CYCLES - 1 : delay;
    lastlow = extra ? cs_low_at + 2 * PH : cs_low_at;
    early   = (lastlow <= CONV_CYCLES - 2);
    for (int k = 0; k <= CONV_CYCLES + 2; k++) begin
      chk("sample_req", 32'(sample_req), 32'(k <= lastreq));
      chk("err_nodata", 32'(err_nodata), 32'(exp_nod && k == CONV_CYCLES));
      chk("busy_conv", 32'(busy), 1);
      if (k <= CONV_CYCLES) chk("dout_conv", 32'(adc_dout), 0);
      else if (k == CONV_CYCLES + 1)
        chk("dout_ready", 32'(adc_dout), 32'(early ? exp_res[11] : 1'b0));
      if (k == delay) begin
        sample_valid = 1'b1;
        sample_data  = data;
      end else if (delay >= 0 && k == delay + 2) begin
        sample_valid = 1'b1;
        sample_data  = ~data;
      end else begin
        sample_valid = 1'b0;
        sample_data  = 12'($urandom);
      end
      adc_cs = (k < cs_low_at) || (extra && k >= cs_low_at + PH && k < cs_low_at + 2 * PH);
      tick(1);
    end
    adc_cs = 1'b0;
    sample_valid = 1'b0;
    tick(PH);
  endtask

  // Master side of the frame: DIN set up while SCLK is low, DOUT sampled at each rise.
  task automatic frame(input logic [5:0] cfgw, input int nper, output logic [11:0] got);
    got = '0;
    for (int i = 0; i < nper; i++) begin
      adc_din = (i < 6) ? cfgw[5 - i] : 1'($urandom);
      tick(PH);
      got = {got[10:0], adc_dout};
      adc_sclk = 1'b1;
      tick(PH);
      adc_sclk = 1'b0;
    end
  endtask

  task automatic post_checks(input logic [5:0] cfgw, input logic [11:0] got, input logic [11:0] res,
                             input bit nod, input int v0, input int d0, input int a0, input int exp_abt);
    tick(PH);
    chk("dout_bits", 32'(got), 32'(res));
    chk("cfg_word", 32'(cfg_word), 32'(cfgw));
    chk("cfg_valid_pulses", n_cfgv - v0, 1);
    chk("nodata_pulses", n_nod - d0, 32'(nod));
    chk("abort_pulses", n_abt - a0, exp_abt);
    chk("busy_idle", 32'(busy), 0);
    chk("dout_idle", 32'(adc_dout), 0);
    chk("req_idle", 32'(sample_req), 0);
    m_cfg = cfgw;
  endtask

  task automatic full_txn(input int delay, input logic [11:0] data, input int cs_low_at,
                          input bit extra, input logic [5:0] cfgw);
    int v0, d0, a0;
    logic [11:0] res, got;
    bit nod;
    v0 = n_cfgv;
    d0 = n_nod;
    a0 = n_abt;
    conversion(delay, data, cs_low_at, extra, res, nod);
    frame(cfgw, 12, got);
    post_checks(cfgw, got, res, nod, v0, d0, a0, 0);
  endtask

  initial begin
    logic [11:0] res, got;
    bit nod;
    int v0, d0, a0, b0;
    reset = 1'b1; adc_cs = 1'b0; adc_sclk = 1'b0; adc_din = 1'b0;
    sample_data = '0; sample_valid = 1'b0;
    m_cfg = CFG_DEFAULT;
    tick(3);
    reset_checks();
    reset = 1'b0;
    tick(2);

    // Default config, CH0, sample three cycles after the request.
    full_txn(3, 12'hA5C, 6, 1'b0, 6'b110010);
    // No sample at all: all-ones result and an error pulse.
    full_txn(-1, 12'h123, 10, 1'b0, 6'b011101);
    // CONVST already low at end of conversion, MSB set so the single READY cycle is visible.
    full_txn(20, 12'h801, 2, 1'b0, 6'b100110);
    // Sample on the last conversion cycle; CONVST held past the end (READY waits).
    full_txn(CONV_CYCLES - 1, 12'h9E7, CONV_CYCLES + 1, 1'b0, 6'b010001);
    // Sample one cycle too late counts as missing.
    full_txn(CONV_CYCLES, 12'h456, 5, 1'b0, 6'b110100);

    // Abort after five SCLK periods.
    conversion(7, 12'hC3A, 4, 1'b0, res, nod);
    frame(6'b001111, 5, got);
    chk("dout_partial", 32'(got[4:0]), 32'(res[11:7]));
    v0 = n_cfgv; d0 = n_nod; a0 = n_abt; b0 = n_busy_lo;
    conversion(12, 12'h3C5, 6, 1'b0, res, nod);
    chk("abort_pulse", n_abt - a0, 1);
    chk("abort_cfg_kept", 32'(cfg_word), 32'(m_cfg));
    chk("abort_busy_held", n_busy_lo - b0, 0);
    frame(6'b101011, 12, got);
    post_checks(6'b101011, got, res, nod, v0, d0, a0, 1);

    // Reset after the 7th SCLK edge (4th rise).
    conversion(4, 12'h777, 3, 1'b0, res, nod);
    frame(6'b011000, 3, got);
    adc_din = 1'b1;
    tick(PH);
    adc_sclk = 1'b1;
    tick(PH);
    reset = 1'b1;
    tick(1);
    reset_checks();
    reset = 1'b0;
    adc_sclk = 1'b0;
    m_cfg = CFG_DEFAULT;
    tick(PH);
    full_txn(9, 12'h5A5, 5, 1'b0, 6'b100010);

    // SCLK activity while idle, then a second CONVST edge during conversion.
    v0 = n_cfgv; d0 = n_nod; a0 = n_abt;
    for (int i = 0; i < 4; i++) begin
      adc_din = 1'($urandom);
      adc_sclk = 1'b1;
      tick(PH);
      adc_sclk = 1'b0;
      tick(PH);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_dout", 32'(adc_dout), 0);
    end
    chk("idle_cfg_word", 32'(cfg_word), 32'(m_cfg));
    chk("idle_events", (n_cfgv - v0) + (n_nod - d0) + (n_abt - a0), 0);
    full_txn(15, 12'h2D9, 10, 1'b1, 6'b111000);

    for (int it = 0; it < 8; it++) begin
      int r, d, cl;
      bit ex;
      r = int'($urandom_range(0, 9));
      if (r < 6)       d = int'($urandom_range(0, CONV_CYCLES - 1));
      else if (r == 6) d = CONV_CYCLES - 1;
      else if (r == 7) d = CONV_CYCLES;
      else if (r == 8) d = -1;
      else             d = 0;
      if ($urandom_range(0, 1) == 1) cl = int'($urandom_range(1, 40));
      else                           cl = CONV_CYCLES + 1 + int'($urandom_range(0, 1));
      ex = (cl <= 40) && ($urandom_range(0, 1) == 1);
      full_txn(d, 12'($urandom), cl, ex, 6'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
